fb_swap_ctrl: RTL and testbench
===============================

Name: fb_swap_ctrl

Overview:
Sequencing controller for the ping-pong frame buffer (two 1024 x 12-bit single-port BRAMs, one written while the other is read).
- Write side: accepts pixels from the lava-lamp renderer over a valid/ready stream and generates sequential write addresses.
- Read side: serves display-scan pull requests with sequential read addresses and aligned data.
- Swap: issues the one-cycle swap only when the back buffer is full and the display has finished its current frame.
- Placement: between the renderer, the display driver and the double-buffer module.

Parameters:
DEPTH, 1024, pixels per frame (entries per buffer).
AW, 10, address width, equals clog2(DEPTH).
DW, 12, pixel width (4:4:4 RGB).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  renderer pixel valid
wr_data  in  DW  renderer pixel
wr_ready  out  1  controller accepts pixel this cycle
rd_req  in  1  display requests next pixel
rd_ready  out  1  request accepted this cycle
rd_valid  out  1  rd_data valid (1 cycle after accepted req)
rd_data  out  DW  pixel from front buffer
rd_last  out  1  qualifies rd_valid: last pixel of frame
buf_en  out  1  buffer enable
buf_swap_en  out  1  one-cycle swap strobe
buf_w_en  out  1  buffer write enable
buf_w_addr  out  AW  back-buffer write address
buf_r_addr  out  AW  front-buffer read address
buf_din  out  DW  write data (= wr_data)
buf_dout  in  DW  buffer read data
swap_pending  out  1  back buffer full, waiting on reader

Behaviour:
- Reset (async assert, sync release): state=FILL, w_ptr=0, r_ptr=0, rd_done=0.
  - All outputs 0 during reset.
  - buf_en=1 from the first cycle after release.
  - Buffer select is not reset by this block; the controller is agnostic to which physical RAM is front.
- FSM states: FILL, WAIT, SWAP, SETTLE0, SETTLE1.
- FILL:
  - wr_ready=1. Write accepted when wr_valid&wr_ready.
  - On accept: buf_w_en=1, buf_w_addr=w_ptr, buf_din=wr_data, w_ptr++.
  - Write accepted at w_ptr==DEPTH-1: w_ptr wraps to 0, next state WAIT.
- WAIT:
  - wr_ready=0, swap_pending=1.
  - Moves to SWAP when rd_done=1 and no read is in flight (rd_valid=0 this cycle).
- SWAP: buf_swap_en=1 for exactly one cycle. Clears rd_done and r_ptr. Next state SETTLE0.
- SETTLE0 -> SETTLE1 -> FILL:
  - Two-cycle hold covers the buffer's one-cycle read latency and its delayed output-select.
  - In SWAP/SETTLE0/SETTLE1: wr_ready=0 and rd_ready=0.
- Read side:
  - rd_ready=1 in FILL and WAIT, except when rd_done=1 and state=WAIT (reader stalls at frame end until swap).
  - On accept: buf_r_addr=r_ptr, r_ptr++.
  - The next cycle: rd_valid=1, rd_data=buf_dout.
  - Accept at r_ptr==DEPTH-1: r_ptr wraps to 0, rd_done set, and the following rd_valid carries rd_last=1.
  - In FILL with rd_done=1: reader may re-scan the same front frame from 0. rd_done stays set, and rd_last is still flagged per wrap.
- Continuous streaming: back-to-back accepts allowed every cycle on both sides, so throughput is 1 pixel/cycle/side.
- buf_r_addr and buf_w_addr are registered-free combinational from pointers. buf_r_addr = r_ptr whenever rd_ready.
- Simultaneous events:
  - Last write accepted in the same cycle the reader wraps: WAIT entered with rd_done=1. SWAP follows after the in-flight rd_valid cycle, i.e. 2 cycles later.
  - Reset mid-frame discards both partial frames; no swap is issued.

Optional Feature:
FB_FRAME_CNT_EN:
- Defined: adds output frame_cnt [15:0]. Reset 0, increments (wrapping) in the SWAP cycle. Adds output drop_cnt [15:0], incremented each cycle in WAIT where wr_valid=1 (renderer stalled).
- Undefined: neither port exists and no counter logic is synthesised.

Decomposition:
- Package fb_pkg: DEPTH/AW/DW constants, state enum fb_state_t {FILL, WAIT, SWAP, SETTLE0, SETTLE1}, pixel_t typedef logic [DW-1:0].
- One natural sub-module: fb_addr_ctr (wrapping pointer with inc/clr inputs and terminal-count output), instantiated for w_ptr and r_ptr.

Test Plan:
- Reset then stream 1024 pixels (value=addr) with rd_req idle -> wr_ready drops after 1024th accept; swap_pending=1; no buf_swap_en.
- Then rd_req held 1 for 1024 cycles -> rd_last on 1024th rd_valid. buf_swap_en pulses once, 2 cycles after the last rd_valid. rd_ready=0 for 3 cycles, then rd_data of addresses 0..3 = 0..3.
- Both sides continuous from reset for 3 frames (frame n pixel = n*1024+addr, truncated to 12 bits) -> each read frame equals the previously written frame; exactly one swap per frame.
- Renderer wr_valid toggling 50% and reader rd_req toggling 30% -> no pixel lost or duplicated; read/write addresses strictly sequential with wrap 1023->0.
- Assert rst_n low at write pointer 500 -> all outputs 0 asynchronously; after release w_ptr=0, r_ptr=0, state FILL, no swap strobe.
- With FB_FRAME_CNT_EN: 2 completed swaps plus 7 stalled wr_valid cycles in WAIT -> frame_cnt=2, drop_cnt=7.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared constants and types for the ping-pong frame buffer controller.
//   DEPTH   - pixels per frame (entries per buffer)
//   AW      - buffer address width
//   DW      - pixel width (4:4:4 RGB)
//   fb_state_t - sequencing states of fb_swap_ctrl
//   pixel_t / addr_t - pixel and buffer address types
package fb_pkg;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned DW    = 12;

    typedef enum logic [2:0] {
        FILL,
        WAIT,
        SWAP,
        SETTLE0,
        SETTLE1
    } fb_state_t;

    typedef logic [DW-1:0] pixel_t;
    typedef logic [AW-1:0] addr_t;

endpackage

// File: rtl/fb_addr_ctr.sv
// fb_addr_ctr: wrapping frame-buffer pointer.
//   clk, rst_n - clock, asynchronous active-low reset (pointer resets to 0)
//   inc_i      - advance the pointer; wraps DEPTH-1 -> 0
//   clr_i      - force the pointer back to 0 (wins over inc_i)
//   ptr_o      - current pointer
//   tc_o       - terminal count: pointer is at DEPTH-1
module fb_addr_ctr
    import fb_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inc_i,
    input  logic  clr_i,
    output addr_t ptr_o,
    output logic  tc_o
);

    addr_t ptr_q;
    addr_t ptr_d;

    assign tc_o  = (ptr_q == AW'(DEPTH - 1));
    assign ptr_o = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = tc_o ? '0 : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: sequencing controller for a ping-pong frame buffer.
// The renderer fills the back buffer over a valid/ready stream; the display pulls
// pixels from the front buffer; a one-cycle swap strobe is issued once the back
// buffer is full and the reader has finished its frame.
//   clk, rst_n              - clock, asynchronous active-low reset
//   wr_valid/wr_data/wr_ready - renderer pixel stream
//   rd_req/rd_ready          - display pull request / accept
//   rd_valid/rd_data/rd_last - returned pixel, one cycle after accept
//   buf_*                    - double-buffer module interface
//   swap_pending             - back buffer full, waiting for the reader
// Optional build macro FB_FRAME_CNT_EN adds frame_cnt (swaps) and drop_cnt
// (cycles the renderer was stalled while waiting for the reader).
module fb_swap_ctrl
    import fb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_req,
    output logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          buf_en,
    output logic          buf_swap_en,
    output logic          buf_w_en,
    output logic [AW-1:0] buf_w_addr,
    output logic [AW-1:0] buf_r_addr,
    output logic [DW-1:0] buf_din,
    input  logic [DW-1:0] buf_dout,
    output logic          swap_pending
`ifdef FB_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt,
    output logic [15:0]   drop_cnt
`endif
);

    fb_state_t state_q, state_d;
    // en_q holds every handshake low until the first cycle after reset release.
    logic      en_q;
    logic      rd_done_q, rd_done_d;
    logic      rd_valid_q, rd_valid_d;
    logic      rd_last_q, rd_last_d;
    logic      swap_q, swap_d;
    logic      pending_q, pending_d;

    logic      wr_acc, rd_acc;
    logic      w_tc, r_tc;
    addr_t     w_ptr, r_ptr;

    // Handshakes.
    assign wr_ready = en_q && (state_q == FILL);
    // Reader stalls at frame end while waiting for the swap.
    assign rd_ready = en_q && ((state_q == FILL) || ((state_q == WAIT) && !rd_done_q));
    assign wr_acc   = wr_valid && wr_ready;
    assign rd_acc   = rd_req && rd_ready;

    fb_addr_ctr u_w_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (wr_acc),
        .clr_i (1'b0),
        .ptr_o (w_ptr),
        .tc_o  (w_tc)
    );

    fb_addr_ctr u_r_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (rd_acc),
        .clr_i (state_q == SWAP),
        .ptr_o (r_ptr),
        .tc_o  (r_tc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (wr_acc && w_tc) state_d = WAIT;
            // rd_valid_q high means a read from the old front buffer is still returning.
            WAIT:    if (rd_done_q && !rd_valid_q) state_d = SWAP;
            SWAP:    state_d = SETTLE0;
            SETTLE0: state_d = SETTLE1;
            SETTLE1: state_d = FILL;
            default: state_d = FILL;
        endcase

        rd_done_d = rd_done_q;
        if (state_q == SWAP) begin
            rd_done_d = 1'b0;
        end else if (rd_acc && r_tc) begin
            rd_done_d = 1'b1;
        end

        rd_valid_d = rd_acc;
        rd_last_d  = rd_acc && r_tc;
        swap_d     = (state_d == SWAP);
        pending_d  = (state_d == WAIT);
    end

`ifdef FB_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (state_q == SWAP) frame_cnt_d = frame_cnt_q + 16'd1;
        if ((state_q == WAIT) && wr_valid) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            en_q        <= 1'b0;
            rd_done_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            swap_q      <= 1'b0;
            pending_q   <= 1'b0;
`ifdef FB_FRAME_CNT_EN
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            en_q        <= 1'b1;
            rd_done_q   <= rd_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            swap_q      <= swap_d;
            pending_q   <= pending_d;
`ifdef FB_FRAME_CNT_EN
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
`endif
        end
    end

    // Buffer interface; data paths are forced to 0 while held in reset.
    assign buf_en       = en_q;
    assign buf_swap_en  = swap_q;
    assign buf_w_en     = wr_acc;
    assign buf_w_addr   = w_ptr;
    assign buf_r_addr   = r_ptr;
    assign buf_din      = en_q ? wr_data : '0;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_valid_q ? buf_dout : '0;
    assign rd_last      = rd_last_q;
    assign swap_pending = pending_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// tb_fb_swap_ctrl: self-checking bench for fb_swap_ctrl.
// A behavioural two-RAM buffer sits on the buf_* side; a frame-level reference
// model (front/back frame arrays, read/write indices, expected-return queue)
// predicts handshakes, addresses, returned pixels and swap timing.
// Build with FB_FRAME_CNT_EN defined to also cover frame_cnt/drop_cnt.
`timescale 1ns/1ps
module tb_fb_swap_ctrl;
    import fb_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_valid = 1'b0;
    pixel_t        wr_data = '0;
    logic          wr_ready;
    logic          rd_req = 1'b0;
    logic          rd_ready, rd_valid, rd_last;
    pixel_t        rd_data;
    logic          buf_en, buf_swap_en, buf_w_en, swap_pending;
    logic [AW-1:0] buf_w_addr, buf_r_addr;
    pixel_t        buf_din, buf_dout;
`ifdef FB_FRAME_CNT_EN
    logic [15:0]   frame_cnt, drop_cnt;
`endif

    always #5 clk = ~clk;

    fb_swap_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_req       (rd_req),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .buf_en       (buf_en),
        .buf_swap_en  (buf_swap_en),
        .buf_w_en     (buf_w_en),
        .buf_w_addr   (buf_w_addr),
        .buf_r_addr   (buf_r_addr),
        .buf_din      (buf_din),
        .buf_dout     (buf_dout),
        .swap_pending (swap_pending)
`ifdef FB_FRAME_CNT_EN
        ,
        .frame_cnt    (frame_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    function automatic pixel_t init0(input int i);
        return pixel_t'(i * 5 + 17);
    endfunction

    function automatic pixel_t init1(input int i);
        return pixel_t'(i * 3 + 901);
    endfunction

    // Behavioural ping-pong buffer: write back, read front, 1-cycle read latency.
    pixel_t ram0 [DEPTH];
    pixel_t ram1 [DEPTH];
    logic   ram_sel = 1'b0;
    logic   ram_inited = 1'b0;
    pixel_t ram_dout = '0;
    assign buf_dout = ram_dout;

    always @(posedge clk) begin
        if (!ram_inited) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram0[i] <= init0(i);
                ram1[i] <= init1(i);
            end
            ram_inited <= 1'b1;
        end else begin
            if (buf_w_en) begin
                if (ram_sel) ram0[buf_w_addr] <= buf_din;
                else         ram1[buf_w_addr] <= buf_din;
            end
            if (buf_en) ram_dout <= ram_sel ? ram1[buf_r_addr] : ram0[buf_r_addr];
            if (buf_swap_en) ram_sel <= !ram_sel;
        end
    end

    // Reference model state.
    pixel_t m_front [DEPTH];
    pixel_t m_back  [DEPTH];
    int     m_widx, m_ridx, m_wtot, m_wframes, m_swaps, m_drops, m_settle, m_cyc;
    bit     m_full, m_rdone, m_due, m_en;
    pixel_t exp_data_q [$];
    bit     exp_last_q [$];
    int     dut_wacc, dut_swaps;
    int     n_cmp = 0;
    int     n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negative edge: compares this cycle's outputs and advances the model
    // by the transfers that complete at the next rising edge.
    task automatic observe();
        bit exp_swap, exp_wr_rdy, exp_rd_rdy, had_valid, wacc, racc;
        exp_swap = m_due;
        chk("swap_en", buf_swap_en, exp_swap);
        chk("buf_en", buf_en, m_en);
        chk("swap_pending", swap_pending, m_full && !exp_swap);
`ifdef FB_FRAME_CNT_EN
        chk("frame_cnt", frame_cnt, m_swaps % 65536);
        chk("drop_cnt", drop_cnt, m_drops % 65536);
`endif
        exp_wr_rdy = m_en && !m_full && (m_settle == 0) && !exp_swap;
        exp_rd_rdy = m_en && (m_settle == 0) && !exp_swap && !(m_full && m_rdone);
        chk("wr_ready", wr_ready, exp_wr_rdy);
        chk("rd_ready", rd_ready, exp_rd_rdy);

        had_valid = (exp_data_q.size() != 0);
        chk("rd_valid", rd_valid, had_valid);
        if (had_valid) begin
            chk("rd_data", rd_data, exp_data_q.pop_front());
            chk("rd_last", rd_last, exp_last_q.pop_front());
        end else begin
            chk("rd_last_idle", rd_last, 0);
        end

        m_due = m_full && m_rdone && !had_valid && !exp_swap;
        if (m_full && !exp_swap && wr_valid) m_drops++;

        if (exp_swap) begin
            m_front  = m_back;
            m_full   = 1'b0;
            m_rdone  = 1'b0;
            m_ridx   = 0;
            m_swaps++;
            m_settle = 2;
        end else if (m_settle > 0) begin
            m_settle--;
        end

        wacc = wr_valid && exp_wr_rdy;
        chk("buf_w_en", buf_w_en, wacc);
        if (wacc) begin
            chk("w_addr", buf_w_addr, m_widx);
            chk("buf_din", buf_din, wr_data);
            m_back[m_widx] = wr_data;
            m_widx++;
            m_wtot++;
            if (m_widx == DEPTH) begin
                m_widx = 0;
                m_full = 1'b1;
                m_wframes++;
            end
        end

        racc = rd_req && exp_rd_rdy;
        if (racc) begin
            chk("r_addr", buf_r_addr, m_ridx);
            exp_data_q.push_back(m_front[m_ridx]);
            exp_last_q.push_back(m_ridx == DEPTH - 1);
            m_ridx++;
            if (m_ridx == DEPTH) begin
                m_ridx  = 0;
                m_rdone = 1'b1;
            end
        end
    endtask

    task automatic step(input bit wv, input pixel_t wd, input bit rr);
        @(posedge clk);
        if (rst_n) m_en = 1'b1;
        #1;
        wr_valid = wv;
        wr_data  = wd;
        rd_req   = rr;
        @(negedge clk);
        m_cyc++;
        observe();
        if (wr_valid && wr_ready) dut_wacc++;
        if (buf_swap_en) dut_swaps++;
    endtask

    // Asserts reset mid low-phase, checks outputs drop at once, releases on a negedge.
    task automatic do_reset();
        #2;
        rst_n    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 12'hA5A;
        rd_req   = 1'b1;
        #1;
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_buf_en", buf_en, 0);
        chk("rst_swap_en", buf_swap_en, 0);
        chk("rst_w_en", buf_w_en, 0);
        chk("rst_w_addr", buf_w_addr, 0);
        chk("rst_r_addr", buf_r_addr, 0);
        chk("rst_din", buf_din, 0);
        chk("rst_pending", swap_pending, 0);
`ifdef FB_FRAME_CNT_EN
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        rst_n    = 1'b1;
        m_widx = 0; m_ridx = 0; m_wtot = 0; m_wframes = 0; m_swaps = 0; m_drops = 0;
        m_settle = 0; m_full = 1'b0; m_rdone = 1'b0; m_due = 1'b0; m_en = 1'b0;
        exp_data_q.delete();
        exp_last_q.delete();
        dut_wacc = 0;
        dut_swaps = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int     last_cyc, swap_cyc, s0;
        logic   rdy_sw;
        logic   rdy [8];
        pixel_t got [$];

        for (int i = 0; i < DEPTH; i++) m_front[i] = init0(i);
        @(negedge clk);
        do_reset();

        // Post-reset: FILL, pointers at 0, no strobe.
        step(1'b0, '0, 1'b0);
        chk("rel_w_addr", buf_w_addr, 0);
        chk("rel_r_addr", buf_r_addr, 0);

        // Fill one frame with value = address, reader idle.
        for (int i = 0; i < 1100; i++) step(1'b1, pixel_t'(m_widx), 1'b0);
        chk("fill_accepts", dut_wacc, DEPTH);
        chk("fill_pending", swap_pending, 1);
        chk("fill_no_swap", dut_swaps, 0);

        // Drain the front frame; swap two cycles after the last rd_valid.
        last_cyc = -1;
        swap_cyc = -1;
        rdy_sw   = 1'b1;
        for (int i = 0; i < 1500 && swap_cyc < 0; i++) begin
            step(1'b0, '0, 1'b1);
            if (rd_valid && rd_last && last_cyc < 0) last_cyc = m_cyc;
            if (buf_swap_en) begin
                swap_cyc = m_cyc;
                rdy_sw   = rd_ready;
            end
        end
        chk("swap_seen", swap_cyc >= 0, 1);
        chk("swap_gap", swap_cyc - last_cyc, 2);
        chk("rdy_at_swap", rdy_sw, 0);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, '0, 1'b1);
            rdy[k] = rd_ready;
            if (rd_valid) got.push_back(rd_data);
        end
        chk("rdy_settle0", rdy[0], 0);
        chk("rdy_settle1", rdy[1], 0);
        chk("rdy_fill", rdy[2], 1);
        chk("post_swap_reads", got.size() >= 4, 1);
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) chk("post_swap_data", got[k], k);
        end

        // Both sides continuous from reset for three frames.
        do_reset();
        for (int i = 0; i < 5000 && dut_swaps < 3; i++) step(1'b1, pixel_t'(m_wtot), 1'b1);
        chk("cont_swaps", dut_swaps, 3);
        chk("frames_per_swap", m_wframes, dut_swaps);

        // Random throttling: writer ~50%, reader ~30%.
        s0 = dut_swaps;
        for (int i = 0; i < 12000; i++) begin
            step(1'($urandom_range(0, 1)), pixel_t'($urandom), $urandom_range(0, 9) < 3);
        end
        chk("rand_swaps", dut_swaps > s0, 1);

        // Reset in the middle of a frame at write pointer 500.
        for (int i = 0; i < 6000 && m_widx != 500; i++) step(1'b1, pixel_t'($urandom), 1'b1);
        chk("reach_wptr500", m_widx, 500);
        do_reset();
        step(1'b0, '0, 1'b0);
        chk("rst2_w_addr", buf_w_addr, 0);
        chk("rst2_r_addr", buf_r_addr, 0);
        for (int i = 0; i < 5; i++) step(1'b1, pixel_t'($urandom), 1'b0);
        chk("rst2_no_swap", dut_swaps, 0);

`ifdef FB_FRAME_CNT_EN
        // Two swaps, with seven stalled renderer cycles during the second wait.
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 1100 && !m_full; i++) step(1'b1, pixel_t'($urandom), 1'b0);
            if (f == 1) begin
                for (int i = 0; i < 7; i++) step(1'b1, pixel_t'($urandom), 1'b0);
            end
            s0 = dut_swaps;
            for (int i = 0; i < 1200 && dut_swaps == s0; i++) step(1'b0, '0, 1'b1);
        end
        step(1'b0, '0, 1'b0);
        chk("frame_cnt_2", frame_cnt, 2);
        chk("drop_cnt_7", drop_cnt, 7);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
